dram_arb: RTL

//  Two-client request arbiter and response router that drives dram_phy.

---
 rtl/dram_arb_if.sv | 52 +++++
 rtl/dram_arb.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arb_if.sv
// dram_arb_if: client request, read response and dram_phy signals of dram_arb.
//  slave  : the arbiter's view (drives ready, rsp_*, phy_* commands)
//  master : the environment's view (clients, response consumer, phy)
//  Params : RAM_ADDR (address width), RAM_DWIDTH (data width)
interface dram_arb_if #(
    parameter int unsigned RAM_ADDR   = 22,
    parameter int unsigned RAM_DWIDTH = 32
);
    logic                  c0_req_valid;
    logic                  c0_req_ready;
    logic                  c0_req_we;
    logic [RAM_ADDR-1:0]   c0_req_addr;
    logic [RAM_DWIDTH-1:0] c0_req_wdata;

    logic                  c1_req_valid;
    logic                  c1_req_ready;
    logic                  c1_req_we;
    logic [RAM_ADDR-1:0]   c1_req_addr;
    logic [RAM_DWIDTH-1:0] c1_req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [RAM_DWIDTH-1:0] rsp_data;

    logic                  phy_wr_en;
    logic                  phy_rd_en;
    logic [RAM_ADDR-1:0]   phy_addr;
    logic [RAM_DWIDTH-1:0] phy_wr_din;
    logic [RAM_DWIDTH-1:0] phy_rd_dout;
    logic                  phy_rd_valid;

    modport slave (
        input  c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata,
        input  c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata,
        output c0_req_ready, c1_req_ready,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready,
        output phy_wr_en, phy_rd_en, phy_addr, phy_wr_din,
        input  phy_rd_dout, phy_rd_valid
    );

    modport master (
        output c0_req_valid, c0_req_we, c0_req_addr, c0_req_wdata,
        output c1_req_valid, c1_req_we, c1_req_addr, c1_req_wdata,
        input  c0_req_ready, c1_req_ready,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready,
        input  phy_wr_en, phy_rd_en, phy_addr, phy_wr_din,
        output phy_rd_dout, phy_rd_valid
    );
endinterface

// File: rtl/dram_arb.sv
// dram_arb: two-client round-robin request arbiter feeding dram_phy, with
// read-owner tracking across the phy latency and an in-order credited
// response FIFO.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : dram_arb_if.slave (client requests, read responses, phy)
//  Optional (macro DRAM_ARB_STATS_EN): stat_rd_cnt, stat_wr_cnt,
//  stat_stall_cnt, 32-bit saturating event counters.
module dram_arb #(
    parameter int unsigned RAM_ADDR   = 22,
    parameter int unsigned RAM_DWIDTH = 32,
    parameter int unsigned RESP_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    dram_arb_if.slave   bus
`ifdef DRAM_ARB_STATS_EN
    ,
    output logic [31:0] stat_rd_cnt,
    output logic [31:0] stat_wr_cnt,
    output logic [31:0] stat_stall_cnt
`endif
);

    localparam int unsigned PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RSP_W = RAM_DWIDTH + 1;

    // Arbiter / issue state
    logic                  rr_last;      // 1: client 1 was served last
    logic [CNT_W-1:0]      outstanding;
    logic                  phy_wr_en_q;
    logic                  phy_rd_en_q;
    logic [RAM_ADDR-1:0]   phy_addr_q;
    logic [RAM_DWIDTH-1:0] phy_wr_din_q;
    logic                  issue_id;

    // Tag FIFO
    logic                  tag_mem [RESP_DEPTH];
    logic [PTR_W-1:0]      tag_wr;
    logic [PTR_W-1:0]      tag_rd;
    logic [CNT_W-1:0]      tag_cnt;

    // Response FIFO
    logic [RSP_W-1:0]      rsp_mem [RESP_DEPTH];
    logic [PTR_W-1:0]      rsp_wr;
    logic [PTR_W-1:0]      rsp_rd;
    logic [CNT_W-1:0]      rsp_cnt;
    logic                  rsp_valid_q;

    // Combinational
    logic                  credit_ok_c;
    logic                  elig0_c;
    logic                  elig1_c;
    logic                  grant0_c;
    logic                  grant1_c;
    logic                  grant_c;
    logic                  sel_we_c;
    logic [RAM_ADDR-1:0]   sel_addr_c;
    logic [RAM_DWIDTH-1:0] sel_wdata_c;
    logic                  rd_acc_c;
    logic                  wr_acc_c;
    logic                  tag_push_c;
    logic                  tag_pop_c;
    logic                  rsp_push_c;
    logic                  rsp_pop_c;
    logic [CNT_W-1:0]      rsp_cnt_next_c;

    // Arbitration: reads need credit, writes never do; a tie goes to the
    // client not served last.
    always_comb begin
        credit_ok_c = (outstanding < CNT_W'(RESP_DEPTH));
        elig0_c     = bus.c0_req_valid & (bus.c0_req_we | credit_ok_c);
        elig1_c     = bus.c1_req_valid & (bus.c1_req_we | credit_ok_c);
        grant0_c    = elig0_c & (~elig1_c | rr_last);
        grant1_c    = elig1_c & (~elig0_c | ~rr_last);
        grant_c     = grant0_c | grant1_c;
        sel_we_c    = grant1_c ? bus.c1_req_we    : bus.c0_req_we;
        sel_addr_c  = grant1_c ? bus.c1_req_addr  : bus.c0_req_addr;
        sel_wdata_c = grant1_c ? bus.c1_req_wdata : bus.c0_req_wdata;
        rd_acc_c    = grant_c & ~sel_we_c;
        wr_acc_c    = grant_c & sel_we_c;
    end

    assign bus.c0_req_ready = grant0_c;
    assign bus.c1_req_ready = grant1_c;

    // FIFO handshakes; a phy return with no tag is dropped.
    always_comb begin
        tag_push_c     = phy_rd_en_q;
        tag_pop_c      = bus.phy_rd_valid & (tag_cnt != '0);
        rsp_push_c     = tag_pop_c;
        rsp_pop_c      = rsp_valid_q & bus.rsp_ready;
        rsp_cnt_next_c = rsp_cnt;
        case ({rsp_push_c, rsp_pop_c})
            2'b10:   rsp_cnt_next_c = rsp_cnt + CNT_W'(1);
            2'b01:   rsp_cnt_next_c = rsp_cnt - CNT_W'(1);
            default: rsp_cnt_next_c = rsp_cnt;
        endcase
    end

    // Issue register, round-robin pointer and read credit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phy_wr_en_q  <= 1'b0;
            phy_rd_en_q  <= 1'b0;
            phy_addr_q   <= '0;
            phy_wr_din_q <= '0;
            issue_id     <= 1'b0;
            rr_last      <= 1'b1;
            outstanding  <= '0;
        end else begin
            phy_wr_en_q <= wr_acc_c;
            phy_rd_en_q <= rd_acc_c;
            if (grant_c) begin
                phy_addr_q <= sel_addr_c;
                issue_id   <= grant1_c;
                rr_last    <= grant1_c;
                if (sel_we_c) begin
                    phy_wr_din_q <= sel_wdata_c;
                end
            end
            case ({rd_acc_c, rsp_pop_c})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign bus.phy_wr_en  = phy_wr_en_q;
    assign bus.phy_rd_en  = phy_rd_en_q;
    assign bus.phy_addr   = phy_addr_q;
    assign bus.phy_wr_din = phy_wr_din_q;

    // Tag FIFO pointers: owner of each issued read, popped on phy return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
        end else begin
            if (tag_push_c) begin
                tag_wr <= tag_wr + PTR_W'(1);
            end
            if (tag_pop_c) begin
                tag_rd <= tag_rd + PTR_W'(1);
            end
            case ({tag_push_c, tag_pop_c})
                2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
                2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Tag storage
    always_ff @(posedge clk) begin
        if (tag_push_c) begin
            tag_mem[tag_wr] <= issue_id;
        end
    end

    // Response FIFO pointers; rsp_valid registered from the next count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_wr      <= '0;
            rsp_rd      <= '0;
            rsp_cnt     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (rsp_push_c) begin
                rsp_wr <= rsp_wr + PTR_W'(1);
            end
            if (rsp_pop_c) begin
                rsp_rd <= rsp_rd + PTR_W'(1);
            end
            rsp_cnt     <= rsp_cnt_next_c;
            rsp_valid_q <= (rsp_cnt_next_c != '0);
        end
    end

    // Response storage: {owner, data}
    always_ff @(posedge clk) begin
        if (rsp_push_c) begin
            rsp_mem[rsp_wr] <= {tag_mem[tag_rd], bus.phy_rd_dout};
        end
    end

    // Head entry only changes on pop, so rsp_* hold under backpressure
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_mem[rsp_rd][RAM_DWIDTH];
    assign bus.rsp_data  = rsp_mem[rsp_rd][RAM_DWIDTH-1:0];

`ifdef DRAM_ARB_STATS_EN
    logic stall_c;

    // A read waiting only because all credit is in use
    assign stall_c = ~credit_ok_c &
                     ((bus.c0_req_valid & ~bus.c0_req_we) |
                      (bus.c1_req_valid & ~bus.c1_req_we));

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_cnt    <= '0;
            stat_wr_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (rd_acc_c && (stat_rd_cnt != '1)) begin
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
            end
            if (wr_acc_c && (stat_wr_cnt != '1)) begin
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            end
            if (stall_c && (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
